// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default sizing for the two-master memory bus arbiter.
// The build option MEM_ARB_FIXED_PRIO_EN is consumed by the arbiter files, not here.
package mem_bus_arbiter_pkg;

   // Default widths follow the project memory index limits
   localparam int ARB_ADDR_WIDTH    = 26;
   localparam int ARB_DATA_WIDTH    = 32;
   localparam int ARB_ACCESS_CYCLES = 2;
   localparam int ARB_CNT_WIDTH     = 4;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_ACCESS = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_READ  = 2'd1,
      CMD_WRITE = 2'd2
   } arb_cmd_t;

   // A request carrying both READ and WRITE is resolved as a write
   function automatic arb_cmd_t decode_cmd(input logic rd, input logic wr);
      arb_cmd_t cmd;
      if (wr) begin
         cmd = CMD_WRITE;
      end else if (rd) begin
         cmd = CMD_READ;
      end else begin
         cmd = CMD_NONE;
      end
      return cmd;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Two-way winner pick for mem_bus_arbiter: round-robin on ties by default,
// fixed priority to master 0 when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_bus_arbiter_arb_rr2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic unused_last_grant_s;
   assign unused_last_grant_s = last_grant;

   // Master 0 wins whenever it is requesting
   always_comb begin
      if (req[0]) begin
         winner = 1'b0;
      end else begin
         winner = req[1];
      end
   end
`else
   // On a tie the master that did not win last time takes the bus
   always_comb begin
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_grant;
         default: winner = last_grant;
      endcase
   end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between M0 (processor) and M1 (DMA/IO loader).
// Build option MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH    = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH    = ARB_DATA_WIDTH,
   parameter int ACCESS_CYCLES = ARB_ACCESS_CYCLES
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  M0_REQ,
   input  logic                  M0_READ,
   input  logic                  M0_WRITE,
   input  logic [ADDR_WIDTH-1:0] M0_ADDR,
   input  logic [DATA_WIDTH-1:0] M0_DATA,
   output logic                  M0_ACK,
   input  logic                  M1_REQ,
   input  logic                  M1_READ,
   input  logic                  M1_WRITE,
   input  logic [ADDR_WIDTH-1:0] M1_ADDR,
   input  logic [DATA_WIDTH-1:0] M1_DATA,
   output logic                  M1_ACK,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  GRANT,
   output logic                  BUSY,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [DATA_WIDTH-1:0] MEM_DATA_OUT,
   input  logic [DATA_WIDTH-1:0] MEM_DATA_IN
);

   localparam logic [ARB_CNT_WIDTH-1:0] CNT_LOAD = ARB_CNT_WIDTH'(ACCESS_CYCLES - 1);
   localparam logic [ARB_CNT_WIDTH-1:0] CNT_ZERO = ARB_CNT_WIDTH'(0);
   localparam logic [ARB_CNT_WIDTH-1:0] CNT_ONE  = ARB_CNT_WIDTH'(1);

   arb_state_t              state_r, state_s;
   logic [ARB_CNT_WIDTH-1:0] cnt_r, cnt_s;
   arb_cmd_t                cmd_r, cmd_s;
   logic                    grant_r, grant_s;
   logic                    last_grant_r, last_grant_s;
   logic                    busy_r, busy_s;
   logic                    mem_read_r, mem_read_s;
   logic                    mem_write_r, mem_write_s;
   logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_s;
   logic [DATA_WIDTH-1:0]   mem_data_r, mem_data_s;
   logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
   logic [1:0]              ack_r, ack_s;
   logic [1:0]              req_s;
   logic                    win_s;

   assign req_s = {M1_REQ, M0_REQ};

   mem_bus_arbiter_arb_rr2 u_arb_rr2 (
      .req        (req_s),
      .last_grant (last_grant_r),
      .winner     (win_s)
   );

   // Next-state, latch and strobe decode; ACK is a single-cycle pulse by default
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      cmd_s        = cmd_r;
      grant_s      = grant_r;
      last_grant_s = last_grant_r;
      busy_s       = busy_r;
      mem_read_s   = mem_read_r;
      mem_write_s  = mem_write_r;
      mem_addr_s   = mem_addr_r;
      mem_data_s   = mem_data_r;
      rdata_s      = rdata_r;
      ack_s        = 2'b00;
      case (state_r)
         ARB_IDLE: begin
            if (req_s != 2'b00) begin
               state_s      = ARB_ACCESS;
               cnt_s        = CNT_LOAD;
               grant_s      = win_s;
               last_grant_s = win_s;
               busy_s       = 1'b1;
               if (win_s) begin
                  cmd_s      = decode_cmd(M1_READ, M1_WRITE);
                  mem_addr_s = M1_ADDR;
                  mem_data_s = M1_DATA;
               end else begin
                  cmd_s      = decode_cmd(M0_READ, M0_WRITE);
                  mem_addr_s = M0_ADDR;
                  mem_data_s = M0_DATA;
               end
               mem_read_s  = (cmd_s == CMD_READ);
               mem_write_s = (cmd_s == CMD_WRITE);
            end else begin
               state_s = ARB_IDLE;
            end
         end
         ARB_ACCESS: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s = cnt_r - CNT_ONE;
            end else begin
               // Read data is sampled while the strobe is still asserted
               if (cmd_r == CMD_READ) begin
                  rdata_s = MEM_DATA_IN;
               end else begin
                  rdata_s = rdata_r;
               end
               state_s     = ARB_IDLE;
               mem_read_s  = 1'b0;
               mem_write_s = 1'b0;
               busy_s      = 1'b0;
               ack_s       = grant_r ? 2'b10 : 2'b01;
            end
         end
         default: begin
            state_s = ARB_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access without an ACK
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r      <= ARB_IDLE;
         cnt_r        <= CNT_ZERO;
         cmd_r        <= CMD_NONE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         busy_r       <= 1'b0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= 1'b0;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_data_r   <= {DATA_WIDTH{1'b0}};
         rdata_r      <= {DATA_WIDTH{1'b0}};
         ack_r        <= 2'b00;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         cmd_r        <= cmd_s;
         grant_r      <= grant_s;
         last_grant_r <= last_grant_s;
         busy_r       <= busy_s;
         mem_read_r   <= mem_read_s;
         mem_write_r  <= mem_write_s;
         mem_addr_r   <= mem_addr_s;
         mem_data_r   <= mem_data_s;
         rdata_r      <= rdata_s;
         ack_r        <= ack_s;
      end
   end

   assign M0_ACK       = ack_r[0];
   assign M1_ACK       = ack_r[1];
   assign RDATA        = rdata_r;
   assign GRANT        = grant_r;
   assign BUSY         = busy_r;
   assign MEM_READ     = mem_read_r;
   assign MEM_WRITE    = mem_write_r;
   assign MEM_ADDR     = mem_addr_r;
   assign MEM_DATA_OUT = mem_data_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: two instances (ACCESS_CYCLES 2 and 1) share stimulus;
// a transaction-level model pushes expected accesses and a monitor checks the DUT outputs.
module tb_mem_bus_arbiter;

   typedef struct {
      logic        m;
      logic        rd;
      logic        wr;
      logic [25:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      int          start;
      int          ack;
   } txn_t;

   logic        CLK;
   logic        RST;
   logic        M0_REQ, M0_READ, M0_WRITE;
   logic [25:0] M0_ADDR;
   logic [31:0] M0_DATA;
   logic        M1_REQ, M1_READ, M1_WRITE;
   logic [25:0] M1_ADDR;
   logic [31:0] M1_DATA;

   int tests = 0;
   int fails = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] mem_hash(input logic [25:0] a);
      logic [31:0] v;
      if (a == 26'h10) begin
         v = 32'hDEADBEEF;
      end else begin
         v = ({6'd0, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
      end
      return v;
   endfunction

   task automatic check(input string name, input int ac, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (ACCESS_CYCLES=%0d) t=%0t: got %0h expected %0h", name, ac, $time, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int AC = (gi == 0) ? 2 : 1;

      logic        m0_ack, m1_ack, grant, busy, mem_read, mem_write;
      logic [25:0] mem_addr;
      logic [31:0] rdata, mem_dout, mem_din;

      txn_t        sb[$];
      int          e_cnt      = 0;
      int          next_free  = 0;
      logic        last_grant = 1'b1;
      logic [31:0] last_rdata = 32'h0;
      logic        rst_seen   = 1'b0;

      assign mem_din = mem_hash(mem_addr);

      mem_bus_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .ACCESS_CYCLES(AC)) u_dut (
         .CLK(CLK), .RST(RST),
         .M0_REQ(M0_REQ), .M0_READ(M0_READ), .M0_WRITE(M0_WRITE),
         .M0_ADDR(M0_ADDR), .M0_DATA(M0_DATA), .M0_ACK(m0_ack),
         .M1_REQ(M1_REQ), .M1_READ(M1_READ), .M1_WRITE(M1_WRITE),
         .M1_ADDR(M1_ADDR), .M1_DATA(M1_DATA), .M1_ACK(m1_ack),
         .RDATA(rdata), .GRANT(grant), .BUSY(busy),
         .MEM_READ(mem_read), .MEM_WRITE(mem_write),
         .MEM_ADDR(mem_addr), .MEM_DATA_OUT(mem_dout), .MEM_DATA_IN(mem_din)
      );

      // Reference model: bus free every AC+1 edges, winner by arbitration rule
      always @(posedge CLK) begin : p_model
         txn_t        t;
         int          e_now;
         logic        w;
         logic [31:0] rd_val;
         e_now = e_cnt + 1;
         e_cnt <= e_now;
         if (RST == 1'b0) begin
            sb.delete();
            next_free  <= 0;
            last_grant <= 1'b1;
            last_rdata <= 32'h0;
            rst_seen   <= 1'b1;
         end else begin
            rst_seen <= 1'b0;
            if (e_now >= next_free && (M0_REQ || M1_REQ)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
               w = !M0_REQ;
`else
               w = (M0_REQ && M1_REQ) ? !last_grant : M1_REQ;
`endif
               t.m     = w;
               t.wr    = w ? M1_WRITE : M0_WRITE;
               t.rd    = (w ? M1_READ : M0_READ) && !t.wr;
               t.addr  = w ? M1_ADDR : M0_ADDR;
               t.data  = w ? M1_DATA : M0_DATA;
               rd_val  = t.rd ? mem_hash(t.addr) : last_rdata;
               t.rdata = rd_val;
               t.start = e_now;
               t.ack   = e_now + AC;
               sb.push_back(t);
               last_grant <= w;
               last_rdata <= rd_val;
               next_free  <= e_now + AC + 1;
            end
         end
      end

      // Monitor: compare outputs against the scoreboard front every cycle
      always @(negedge CLK) begin : p_mon
         txn_t t;
         #(gi);
         if (e_cnt > 0) begin
            if (rst_seen) begin
               check("reset_ctl", AC, {58'd0, m1_ack, m0_ack, grant, busy, mem_read, mem_write}, 64'd0);
               check("reset_data", AC, {rdata, mem_dout}, 64'd0);
               check("reset_addr", AC, {38'd0, mem_addr}, 64'd0);
            end else if (sb.size() > 0 && e_cnt >= sb[0].start && e_cnt < sb[0].ack) begin
               t = sb[0];
               check("access_ctl", AC, {58'd0, busy, grant, mem_read, mem_write, m1_ack, m0_ack},
                     {58'd0, 1'b1, t.m, t.rd, t.wr, 2'b00});
               check("access_addr", AC, {38'd0, mem_addr}, {38'd0, t.addr});
               if (t.wr) begin
                  check("access_wdata", AC, {32'd0, mem_dout}, {32'd0, t.data});
               end
            end else if (sb.size() > 0 && e_cnt == sb[0].ack) begin
               t = sb.pop_front();
               check("ack", AC, {59'd0, busy, mem_read, mem_write, m1_ack, m0_ack},
                     {59'd0, 3'b000, t.m, ~t.m});
               check("rdata", AC, {32'd0, rdata}, {32'd0, t.rdata});
            end else begin
               check("idle", AC, {59'd0, busy, mem_read, mem_write, m1_ack, m0_ack}, 64'd0);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic set_m(input int m, input logic req, input logic rd, input logic wr,
                        input logic [25:0] a, input logic [31:0] d);
      if (m == 0) begin
         M0_REQ = req; M0_READ = rd; M0_WRITE = wr; M0_ADDR = a; M0_DATA = d;
      end else begin
         M1_REQ = req; M1_READ = rd; M1_WRITE = wr; M1_ADDR = a; M1_DATA = d;
      end
   endtask

   initial begin
      logic [3:0] r;
      RST = 1'b0;
      // Both masters request through two reset edges
      set_m(0, 1'b1, 1'b1, 1'b0, 26'h100, 32'h0);
      set_m(1, 1'b1, 1'b1, 1'b0, 26'h200, 32'h0);
      tick(2);
      RST = 1'b1;
      tick(12);
      set_m(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      tick(4);
      // Single read by M0
      set_m(0, 1'b1, 1'b1, 1'b0, 26'h10, 32'h0);
      tick(1);
      M0_REQ = 1'b0;
      tick(4);
      // Write by M1
      set_m(1, 1'b1, 1'b0, 1'b1, 26'h20, 32'h12345678);
      tick(1);
      M1_REQ = 1'b0;
      tick(4);
      // M1 read, dropping REQ once granted
      set_m(1, 1'b1, 1'b1, 1'b0, 26'h30, 32'h0);
      tick(1);
      M1_REQ = 1'b0;
      tick(4);
      // Reset one edge after grant: aborted, no ACK
      set_m(1, 1'b1, 1'b0, 1'b1, 26'h40, 32'hCAFEF00D);
      tick(1);
      M1_REQ = 1'b0;
      RST = 1'b0;
      tick(1);
      RST = 1'b1;
      tick(4);
      // Corner commands: both set, neither set
      set_m(0, 1'b1, 1'b1, 1'b1, 26'h50, 32'hA5A5A5A5);
      tick(1);
      M0_REQ = 1'b0;
      tick(4);
      set_m(0, 1'b1, 1'b0, 1'b0, 26'h60, 32'h11111111);
      tick(1);
      M0_REQ = 1'b0;
      tick(4);
      // Randomized traffic with occasional reset
      for (int i = 0; i < 800; i++) begin
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 3) == 0) begin
               r = 4'($urandom);
               set_m(m, r[0] | r[3], r[1], r[2], 26'($urandom_range(0, 255)), $urandom);
            end
         end
         RST = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      RST = 1'b1;
      set_m(0, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
      tick(20);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
